// File: rtl/prbs_symbol_generator.sv
// -----------------------------------------------------------------------------
// prbs_symbol_generator
//
// Produces a stream of signed bipolar samples (+AMPLITUDE for bit 1,
// -AMPLITUDE for bit 0). Each symbol bit is repeated for sps samples. The
// symbol source is selected at load time:
//   00 PRBS7 (x^7 + x^6 + 1), 01 PRBS15 (x^15 + x^14 + 1),
//   10 rotating fixed pattern, 11 alternating 1/0.
// Output uses a valid/ready handshake. A presented sample is held until it is
// accepted, and samples are only produced while enable is high.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   enable       : allow new samples to be generated
//   load         : one-cycle strobe; latches mode/sps/seed/pattern, restarts
//   mode         : symbol source select (see above)
//   sps          : samples per symbol (0 behaves as 1)
//   seed         : LFSR seed (PRBS7 uses seed[6:0])
//   pattern      : fixed-pattern bits, MSB sent first
//   out_ready    : downstream accepts the presented sample
//   samples      : registered signed sample
//   sample_valid : samples holds a valid sample
//   symbol_start : presented sample is the first of its symbol
//   bit_out      : symbol bit of the presented sample
//   lockup       : sticky; a zero seed was loaded in a PRBS mode
// -----------------------------------------------------------------------------
module prbs_symbol_generator #(
  parameter int SAMPLE_W  = 8,
  parameter int AMPLITUDE = 1,
  parameter int SPS_W     = 8,
  parameter int PATTERN_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [1:0]           mode,
  input  logic [SPS_W-1:0]     sps,
  input  logic [14:0]          seed,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 out_ready,
  output logic [SAMPLE_W-1:0]  samples,
  output logic                 sample_valid,
  output logic                 symbol_start,
  output logic                 bit_out,
  output logic                 lockup
);

  localparam logic [1:0] MODE_PRBS7   = 2'b00;
  localparam logic [1:0] MODE_PRBS15  = 2'b01;
  localparam logic [1:0] MODE_PATTERN = 2'b10;
  localparam logic [1:0] MODE_ALT     = 2'b11;

  localparam logic [SAMPLE_W-1:0] POS_LEVEL = SAMPLE_W'(AMPLITUDE);
  localparam logic [SAMPLE_W-1:0] NEG_LEVEL = ~POS_LEVEL + 1'b1;

  // Latched configuration
  logic [1:0]           mode_reg;
  logic [SPS_W-1:0]     sps_eff_reg;

  // Symbol sources; each keeps its own state so only the selected one moves
  logic [6:0]           prbs7_reg,   prbs7_next;
  logic [14:0]          prbs15_reg,  prbs15_next;
  logic [PATTERN_W-1:0] pattern_reg, pattern_next;
  logic                 alt_reg,     alt_next;

  // Position of the presented (or next to be presented) sample in its symbol
  logic [SPS_W-1:0]     count_reg,   count_next;

  // Output registers
  logic [SAMPLE_W-1:0]  samples_reg;
  logic                 valid_reg;
  logic                 start_reg;
  logic                 bit_reg;
  logic                 lockup_reg;

  logic                 transfer;
  logic                 symbol_end;
  logic                 present;
  logic                 bit_next;

  // Load-time seed handling: an all-zero seed would stall an LFSR forever
  logic                 seed7_zero;
  logic                 seed15_zero;
  logic                 load_seed_zero;
  logic                 load_is_prbs;

  assign transfer   = valid_reg & out_ready;
  assign symbol_end = (count_reg == sps_eff_reg - 1'b1);
  // A new sample may be produced when the output slot is empty or being freed
  assign present    = ~valid_reg | transfer;

  assign seed7_zero     = (seed[6:0] == 7'd0);
  assign seed15_zero    = (seed == 15'd0);
  assign load_is_prbs   = (mode == MODE_PRBS7) || (mode == MODE_PRBS15);
  assign load_seed_zero = (mode == MODE_PRBS7) ? seed7_zero : seed15_zero;

  always_comb begin
    count_next   = count_reg;
    prbs7_next   = prbs7_reg;
    prbs15_next  = prbs15_reg;
    pattern_next = pattern_reg;
    alt_next     = alt_reg;
    bit_next     = 1'b0;

    if (transfer) begin
      if (symbol_end) begin
        count_next = '0;
        case (mode_reg)
          MODE_PRBS7:   prbs7_next   = {prbs7_reg[5:0], prbs7_reg[6] ^ prbs7_reg[5]};
          MODE_PRBS15:  prbs15_next  = {prbs15_reg[13:0], prbs15_reg[14] ^ prbs15_reg[13]};
          MODE_PATTERN: pattern_next = {pattern_reg[PATTERN_W-2:0], pattern_reg[PATTERN_W-1]};
          default:      alt_next     = ~alt_reg;
        endcase
      end else begin
        count_next = count_reg + 1'b1;
      end
    end

    // Bit for the sample produced this cycle comes from the post-transfer state
    case (mode_reg)
      MODE_PRBS7:   bit_next = prbs7_next[6];
      MODE_PRBS15:  bit_next = prbs15_next[14];
      MODE_PATTERN: bit_next = pattern_next[PATTERN_W-1];
      default:      bit_next = alt_next;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_reg    <= MODE_PRBS7;
      sps_eff_reg <= SPS_W'(1);
      prbs7_reg   <= '1;
      prbs15_reg  <= '1;
      pattern_reg <= '1;
      alt_reg     <= 1'b1;
      count_reg   <= '0;
      samples_reg <= '0;
      valid_reg   <= 1'b0;
      start_reg   <= 1'b0;
      bit_reg     <= 1'b0;
      lockup_reg  <= 1'b0;
    end else if (load) begin
      // Restart: drop any held sample and reinitialise every source
      mode_reg    <= mode;
      sps_eff_reg <= (sps == '0) ? SPS_W'(1) : sps;
      prbs7_reg   <= seed7_zero  ? 7'h7F   : seed[6:0];
      prbs15_reg  <= seed15_zero ? 15'h7FFF : seed;
      pattern_reg <= pattern;
      alt_reg     <= 1'b1;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
      if (load_is_prbs) begin
        lockup_reg <= load_seed_zero;
      end
    end else begin
      count_reg   <= count_next;
      prbs7_reg   <= prbs7_next;
      prbs15_reg  <= prbs15_next;
      pattern_reg <= pattern_next;
      alt_reg     <= alt_next;
      if (present) begin
        valid_reg <= enable;
        if (enable) begin
          samples_reg <= bit_next ? POS_LEVEL : NEG_LEVEL;
          bit_reg     <= bit_next;
          start_reg   <= (count_next == '0);
        end
      end
    end
  end

  assign samples      = samples_reg;
  assign sample_valid = valid_reg;
  assign symbol_start = start_reg;
  assign bit_out      = bit_reg;
  assign lockup       = lockup_reg;

endmodule

// File: tb/tb_prbs_symbol_generator.sv
// -----------------------------------------------------------------------------
// tb_prbs_symbol_generator
//
// Scoreboard bench: stimulus pushes the expected sample/bit/start triple for
// every sample it intends to have accepted; a negedge monitor pops one entry
// per handshake transfer and compares. Directed checks cover reset state,
// holding under backpressure, lockup handling and load priority.
// -----------------------------------------------------------------------------
module tb_prbs_symbol_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [1:0]  mode;
  logic [7:0]  sps;
  logic [14:0] seed;
  logic [15:0] pattern;
  logic        out_ready;
  logic [7:0]  samples;
  logic        sample_valid;
  logic        symbol_start;
  logic        bit_out;
  logic        lockup;

  typedef struct packed {
    logic [7:0] smp;
    logic       b;
    logic       st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  prbs_symbol_generator #(
    .SAMPLE_W (8),
    .AMPLITUDE(1),
    .SPS_W    (8),
    .PATTERN_W(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .mode        (mode),
    .sps         (sps),
    .seed        (seed),
    .pattern     (pattern),
    .out_ready   (out_ready),
    .samples     (samples),
    .sample_valid(sample_valid),
    .symbol_start(symbol_start),
    .bit_out     (bit_out),
    .lockup      (lockup)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_bit(input logic b, input logic st);
    exp_t e;
    e.smp = b ? 8'h01 : 8'hFF;
    e.b   = b;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  task automatic push_prbs7(input logic [6:0] s0, input int nsym, input int nsps);
    logic [6:0] s;
    s = s0;
    for (int i = 0; i < nsym; i++) begin
      for (int k = 0; k < nsps; k++) push_bit(s[6], k == 0);
      s = {s[5:0], s[6] ^ s[5]};
    end
  endtask

  task automatic push_prbs15(input logic [14:0] s0, input int nsym);
    logic [14:0] s;
    s = s0;
    for (int i = 0; i < nsym; i++) begin
      push_bit(s[14], 1'b1);
      s = {s[13:0], s[14] ^ s[13]};
    end
  endtask

  // Monitor: one scoreboard entry per accepted sample
  always @(negedge clock) begin
    if (!reset && !load && sample_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: got sample %0h, expected no transfer", samples);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample", samples, e.smp);
        check("bit_out", bit_out, e.b);
        check("symbol_start", symbol_start, e.st);
      end
    end
  end

  task automatic do_load(input logic [1:0] m, input logic [7:0] s,
                         input logic [14:0] sd, input logic [15:0] p);
    load    = 1'b1;
    mode    = m;
    sps     = s;
    seed    = sd;
    pattern = p;
    @(posedge clock);
    #1 load = 1'b0;
  endtask

  // Stream with full handshake until the scoreboard is empty, then stall
  task automatic drain(input int limit);
    int guard;
    guard     = 0;
    enable    = 1'b1;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < limit) begin
      @(posedge clock);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
    enable    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat_a5f0;
    logic [15:0] pat_8001;
    int          guard;

    pat_a5f0  = 16'hA5F0;
    pat_8001  = 16'h8001;
    reset     = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    mode      = 2'b00;
    sps       = 8'd0;
    seed      = 15'd0;
    pattern   = 16'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    check("rst_samples", samples, 8'h00);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_start", symbol_start, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_lockup", lockup, 1'b0);

    // Defaults: PRBS7 from all ones, sps 1, two full periods
    push_prbs7(7'h7F, 254, 1);
    drain(400);

    // sps=4 with backpressure on the second sample
    do_load(2'b00, 8'd4, 15'h007F, 16'h0000);
    push_prbs7(7'h7F, 3, 4);
    enable    = 1'b1;
    out_ready = 1'b0;
    guard     = 0;
    while (!sample_valid && guard < 10) begin
      @(posedge clock);
      #1 guard++;
    end
    check("sps4_first_valid", sample_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("hold_valid", sample_valid, 1'b1);
      check("hold_sample", samples, 8'h01);
      check("hold_start", symbol_start, 1'b0);
    end
    drain(40);

    // PRBS15 zero seed -> lockup, all-ones substitute; nonzero seed clears it
    do_load(2'b01, 8'd1, 15'h0000, 16'h0000);
    check("lockup_set", lockup, 1'b1);
    push_prbs15(15'h7FFF, 40);
    drain(80);
    do_load(2'b01, 8'd1, 15'h0001, 16'h0000);
    check("lockup_clear", lockup, 1'b0);
    push_prbs15(15'h0001, 20);
    drain(50);

    // Fixed pattern A5F0, two rotations
    do_load(2'b10, 8'd1, 15'h0000, 16'hA5F0);
    for (int i = 0; i < 32; i++) push_bit(pat_a5f0[15 - (i % 16)], 1'b1);
    drain(60);

    // Alternating, sps 2; mode/sps inputs changed mid-stream without load
    do_load(2'b11, 8'd2, 15'h0000, 16'h0000);
    for (int i = 0; i < 12; i++) push_bit(((i / 2) % 2) == 0, (i % 2) == 0);
    enable    = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 mode = 2'b00;
    sps = 8'd7;
    drain(40);

    // Load with out_ready high while a sample is held: no transfer, restart
    check("held_before_load", sample_valid, 1'b1);
    for (int i = 0; i < 18; i++) push_bit(pat_8001[15 - (i % 16)], 1'b1);
    enable    = 1'b1;
    out_ready = 1'b1;
    do_load(2'b10, 8'd0, 15'h0000, 16'h8001);
    check("load_clears_valid", sample_valid, 1'b0);
    drain(40);

    // Reset beats a simultaneous load, clears lockup and a held sample
    do_load(2'b00, 8'd3, 15'h0000, 16'h0000);
    check("lockup_prbs7", lockup, 1'b1);
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1 enable = 1'b0;
    check("held_before_reset", sample_valid, 1'b1);
    reset   = 1'b1;
    load    = 1'b1;
    mode    = 2'b01;
    seed    = 15'h0000;
    sps     = 8'd5;
    @(posedge clock);
    #1 reset = 1'b0;
    load = 1'b0;
    check("rst2_valid", sample_valid, 1'b0);
    check("rst2_samples", samples, 8'h00);
    check("rst2_lockup", lockup, 1'b0);
    check("rst2_start", symbol_start, 1'b0);
    push_prbs7(7'h7F, 20, 1);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
